serial_bus_arbiter: RTL and testbench

- Shares one serial-bus slave (slave port + BRAM) between NUM_MASTERS master ports.
- Grants the bus to one requester at a time using round-robin, and holds the grant for the whole transaction.
- Routes the granted master's write data, mode and valid to the slave, and returns the slave's read data and valid to that master only.
- Includes a watchdog that reclaims the bus from a stalled master.

---
 rtl/serial_bus_arb_pkg.sv | 34 +++
 rtl/serial_bus_arbiter_rr_picker.sv | 40 ++++
 rtl/serial_bus_arbiter.sv | 127 ++++++++++++
 tb/tb_serial_bus_arbiter.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/serial_bus_arb_pkg.sv
// Shared types and helpers for the serial bus arbiter.
//   state_t    : arbiter FSM encoding (IDLE / BUSY / RELEASE)
//   bus_req_t  : one master's view of the slave-side bus (wdata, mode, valid)
//   clog2      : ceiling log2 for sizing index fields
//   id_width   : index width, never below one bit
package serial_bus_arb_pkg;

  localparam int DEF_NUM_MASTERS    = 2;
  localparam int DEF_TIMEOUT_CYCLES = 256;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RELEASE = 2'd2
  } state_t;

  typedef struct packed {
    logic wdata;
    logic mode;
    logic valid;
  } bus_req_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int id_width(input int n);
    return (n > 1) ? clog2(n) : 1;
  endfunction

endpackage

// File: rtl/serial_bus_arbiter_rr_picker.sv
// Combinational round-robin selector.
//   req : request vector
//   ptr : index of the last granted master; search starts at ptr+1
//   gnt : one-hot winner (zero if no request)
//   idx : winner index
//   any : at least one request present
module rr_picker
  import serial_bus_arb_pkg::*;
#(
  parameter int NUM_MASTERS = DEF_NUM_MASTERS
) (
  input  logic [NUM_MASTERS-1:0]           req,
  input  logic [id_width(NUM_MASTERS)-1:0] ptr,
  output logic [NUM_MASTERS-1:0]           gnt,
  output logic [id_width(NUM_MASTERS)-1:0] idx,
  output logic                             any
);
  localparam int IDW = id_width(NUM_MASTERS);
  localparam logic [IDW-1:0] LAST = IDW'(NUM_MASTERS - 1);

  logic [IDW-1:0] j;

  // Walk ptr+1, ptr+2, ... with explicit wrap so non-power-of-two
  // master counts never index past the request vector.
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = ptr;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      j = (j == LAST) ? '0 : j + 1'b1;
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = j;
      end
    end
  end

endmodule

// File: rtl/serial_bus_arbiter.sv
// Round-robin arbiter sharing one serial-bus slave between NUM_MASTERS masters.
//   clk, rst      : clock, synchronous active-high reset
//   mreq          : per-master request, held for the whole transaction
//   mgrant        : registered one-hot grant
//   mwdata/mmode/mvalid : per-master bus inputs, only the granted one is routed
//   msrdata       : slave read data, broadcast
//   msvalid       : slave read valid, gated to the granted master
//   bwdata/bmode/bvalid : to the slave
//   srdata/svalid/sready: from the slave
//   gnt_id        : current/last granted master index
//   timeout       : one-cycle pulse when the watchdog reclaims the bus
module serial_bus_arbiter
  import serial_bus_arb_pkg::*;
#(
  parameter int NUM_MASTERS    = DEF_NUM_MASTERS,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int CNT_WIDTH      = 9
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_MASTERS-1:0]           mreq,
  output logic [NUM_MASTERS-1:0]           mgrant,
  input  logic [NUM_MASTERS-1:0]           mwdata,
  input  logic [NUM_MASTERS-1:0]           mmode,
  input  logic [NUM_MASTERS-1:0]           mvalid,
  output logic                             msrdata,
  output logic [NUM_MASTERS-1:0]           msvalid,
  output logic                             bwdata,
  output logic                             bmode,
  output logic                             bvalid,
  input  logic                             srdata,
  input  logic                             svalid,
  input  logic                             sready,
  output logic [id_width(NUM_MASTERS)-1:0] gnt_id,
  output logic                             timeout
);
  localparam int IDW = id_width(NUM_MASTERS);
  localparam logic [CNT_WIDTH-1:0] WD_LAST =
    (TIMEOUT_CYCLES == 0) ? '0 : CNT_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam bit WD_EN = (TIMEOUT_CYCLES != 0);

  state_t                 state, nxt_state;
  logic [NUM_MASTERS-1:0] nxt_grant, pick_gnt;
  logic [IDW-1:0]         ptr, nxt_ptr, nxt_gid, pick_idx;
  logic                   pick_any;
  logic [CNT_WIDTH-1:0]   wdcnt, nxt_cnt;
  logic                   nxt_to;
  logic                   bus_act, wd_fire;
  bus_req_t               bus;

  rr_picker #(.NUM_MASTERS(NUM_MASTERS)) u_pick (
    .req (mreq),
    .ptr (ptr),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  // Mux straight off the registered one-hot grant: a zero grant
  // yields an all-zero bus, so ungranted masters never leak through.
  assign bus.wdata = |(mwdata & mgrant);
  assign bus.mode  = |(mmode  & mgrant);
  assign bus.valid = |(mvalid & mgrant);

  assign bwdata  = bus.wdata;
  assign bmode   = bus.mode;
  assign bvalid  = bus.valid;
  assign msrdata = srdata;
  assign msvalid = mgrant & {NUM_MASTERS{svalid}};

  assign bus_act = bvalid | svalid;
  assign wd_fire = WD_EN && !bus_act && (wdcnt == WD_LAST);

  always_comb begin
    nxt_state = state;
    nxt_grant = mgrant;
    nxt_gid   = gnt_id;
    nxt_ptr   = ptr;
    nxt_cnt   = '0;
    nxt_to    = 1'b0;
    case (state)
      IDLE: begin
        if (pick_any && sready) begin
          nxt_grant = pick_gnt;
          nxt_gid   = pick_idx;
          nxt_state = BUSY;
        end
      end
      BUSY: begin
        // Normal completion wins over a coincident watchdog expiry.
        if (!mreq[gnt_id]) begin
          nxt_grant = '0;
          nxt_ptr   = gnt_id;
          nxt_state = RELEASE;
        end else if (wd_fire) begin
          nxt_grant = '0;
          nxt_ptr   = gnt_id;
          nxt_to    = 1'b1;
          nxt_state = RELEASE;
        end else begin
          nxt_cnt = bus_act ? '0 : wdcnt + 1'b1;
        end
      end
      RELEASE: nxt_state = IDLE;
      default: nxt_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      mgrant  <= '0;
      gnt_id  <= '0;
      ptr     <= IDW'(NUM_MASTERS - 1);
      wdcnt   <= '0;
      timeout <= 1'b0;
    end else begin
      state   <= nxt_state;
      mgrant  <= nxt_grant;
      gnt_id  <= nxt_gid;
      ptr     <= nxt_ptr;
      wdcnt   <= nxt_cnt;
      timeout <= nxt_to;
    end
  end

endmodule

// File: tb/tb_serial_bus_arbiter.sv
module tb_serial_bus_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] mreq, mgrant, mwdata, mmode, mvalid, msvalid;
  logic       msrdata, bwdata, bmode, bvalid, srdata, svalid, sready;
  logic [0:0] gnt_id;
  logic       timeout;

  serial_bus_arbiter #(.NUM_MASTERS(2), .TIMEOUT_CYCLES(8), .CNT_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .mreq(mreq), .mgrant(mgrant), .mwdata(mwdata),
    .mmode(mmode), .mvalid(mvalid), .msrdata(msrdata), .msvalid(msvalid),
    .bwdata(bwdata), .bmode(bmode), .bvalid(bvalid), .srdata(srdata),
    .svalid(svalid), .sready(sready), .gnt_id(gnt_id), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    string      nm;
    logic [9:0] v;   // {mgrant, gnt_id, bvalid, bwdata, bmode, msvalid, timeout, msrdata}
  } exp_t;

  exp_t q[$];
  int   nvec = 0;
  int   nerr = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [1:0] g, input logic id,
                     input logic bv, input logic bw, input logic bm,
                     input logic [1:0] msv, input logic to, input logic srd);
    exp_t e;
    e.cyc = cyc;
    e.nm  = nm;
    e.v   = {g, id, bv, bw, bm, msv, to, srd};
    q.push_back(e);
  endtask

  // Monitor: pops every expectation due this cycle and compares mid-cycle.
  initial begin
    exp_t e;
    logic [9:0] act;
    forever begin
      @(negedge clk);
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        e   = q.pop_front();
        act = {mgrant, gnt_id, bvalid, bwdata, bmode, msvalid, timeout, msrdata};
        nvec++;
        if (e.cyc != cyc || act !== e.v) begin
          nerr++;
          $display("FAIL %s cyc=%0d got {g,id,bv,bw,bm,msv,to,srd}=%b required %b",
                   e.nm, cyc, act, e.v);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL bench_timeout: run did not complete");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst = 1'b1; mreq = 2'b00; mwdata = 2'b00; mmode = 2'b00; mvalid = 2'b00;
    srdata = 1'b0; svalid = 1'b0; sready = 1'b1;

    step(); chk("reset", 2'b00, 0, 0, 0, 0, 2'b00, 0, 0);

    // Master 0 alone: grant one edge after request, its bits on the bus.
    rst = 1'b0; mreq = 2'b01;
    chk("t1_idle", 2'b00, 0, 0, 0, 0, 2'b00, 0, 0);
    step(); mvalid = 2'b01; mwdata = 2'b01; mmode = 2'b00;
    chk("t1_grant", 2'b01, 0, 1, 1, 0, 2'b00, 0, 0);
    step(); mvalid = 2'b01; mwdata = 2'b00; mmode = 2'b01;
    chk("t1_data", 2'b01, 0, 1, 0, 1, 2'b00, 0, 0);

    // Ungranted master 1 drives everything; slave returns read data.
    step(); mvalid = 2'b10; mwdata = 2'b10; mmode = 2'b10; svalid = 1'b1; srdata = 1'b1;
    chk("t3_isolate", 2'b01, 0, 0, 0, 0, 2'b01, 0, 1);
    step(); mreq = 2'b00; mvalid = 2'b00; mwdata = 2'b00; mmode = 2'b00;
    svalid = 1'b0; srdata = 1'b0;
    chk("t1_last", 2'b01, 0, 0, 0, 0, 2'b00, 0, 0);
    step(); mreq = 2'b11;
    chk("t1_release", 2'b00, 0, 0, 0, 0, 2'b00, 0, 0);

    // Both requesting: round-robin 1, 0, 1.
    step(); chk("t2_idle_a", 2'b00, 0, 0, 0, 0, 2'b00, 0, 0);
    step(); mvalid = 2'b10; mwdata = 2'b10; mmode = 2'b10;
    chk("t2_grant1", 2'b10, 1, 1, 1, 1, 2'b00, 0, 0);
    step(); mreq = 2'b01; mvalid = 2'b00; mwdata = 2'b00; mmode = 2'b00;
    chk("t2_busy1", 2'b10, 1, 0, 0, 0, 2'b00, 0, 0);
    step(); mreq = 2'b11;
    chk("t2_release1", 2'b00, 1, 0, 0, 0, 2'b00, 0, 0);
    step(); chk("t2_idle_b", 2'b00, 1, 0, 0, 0, 2'b00, 0, 0);
    step(); mvalid = 2'b01;
    chk("t2_grant0", 2'b01, 0, 1, 0, 0, 2'b00, 0, 0);
    step(); mreq = 2'b10; mvalid = 2'b00;
    chk("t2_busy0", 2'b01, 0, 0, 0, 0, 2'b00, 0, 0);
    step(); mreq = 2'b11;
    chk("t2_release0", 2'b00, 0, 0, 0, 0, 2'b00, 0, 0);
    step(); chk("t2_idle_c", 2'b00, 0, 0, 0, 0, 2'b00, 0, 0);
    step(); mvalid = 2'b10;
    chk("t2_grant1b", 2'b10, 1, 1, 0, 0, 2'b00, 0, 0);

    // Master 1 stalls: 8 silent cycles, then forced release.
    step(); mvalid = 2'b00;
    chk("t5_idle1", 2'b10, 1, 0, 0, 0, 2'b00, 0, 0);
    for (int i = 0; i < 7; i++) begin
      step(); chk("t5_hold", 2'b10, 1, 0, 0, 0, 2'b00, 0, 0);
    end
    step(); chk("t5_timeout", 2'b00, 1, 0, 0, 0, 2'b00, 1, 0);
    step(); chk("t5_pulse_end", 2'b00, 1, 0, 0, 0, 2'b00, 0, 0);
    step(); mvalid = 2'b01;
    chk("t5_next0", 2'b01, 0, 1, 0, 0, 2'b00, 0, 0);

    // Reset mid-transaction drops grant and bus.
    step(); rst = 1'b1;
    chk("t6_pre_rst", 2'b01, 0, 1, 0, 0, 2'b00, 0, 0);
    step(); rst = 1'b0;
    chk("t6_rst", 2'b00, 0, 0, 0, 0, 2'b00, 0, 0);
    step(); chk("t6_first", 2'b01, 0, 1, 0, 0, 2'b00, 0, 0);

    // sready low holds off the grant.
    step(); mreq = 2'b00; mvalid = 2'b00;
    chk("t4_busy", 2'b01, 0, 0, 0, 0, 2'b00, 0, 0);
    step(); mreq = 2'b01; sready = 1'b0;
    chk("t4_release", 2'b00, 0, 0, 0, 0, 2'b00, 0, 0);
    step(); chk("t4_idle", 2'b00, 0, 0, 0, 0, 2'b00, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step(); chk("t4_wait", 2'b00, 0, 0, 0, 0, 2'b00, 0, 0);
    end
    sready = 1'b1;
    step(); chk("t4_grant", 2'b01, 0, 0, 0, 0, 2'b00, 0, 0);

    // Reset while master 1 holds the bus clears gnt_id; master 0 first after.
    step(); mreq = 2'b00;
    chk("t7_busy", 2'b01, 0, 0, 0, 0, 2'b00, 0, 0);
    step(); mreq = 2'b10;
    chk("t7_release", 2'b00, 0, 0, 0, 0, 2'b00, 0, 0);
    step(); chk("t7_idle", 2'b00, 0, 0, 0, 0, 2'b00, 0, 0);
    step(); rst = 1'b1;
    chk("t7_grant1", 2'b10, 1, 0, 0, 0, 2'b00, 0, 0);
    step(); rst = 1'b0; mreq = 2'b11;
    chk("t7_rst", 2'b00, 0, 0, 0, 0, 2'b00, 0, 0);
    step(); svalid = 1'b1;
    chk("t7_first0", 2'b01, 0, 0, 0, 0, 2'b01, 0, 0);

    step(); svalid = 1'b0; mreq = 2'b00;
    repeat (3) step();
    if (q.size() != 0) begin
      nerr += q.size();
      $display("FAIL unchecked: %0d expectations left, required 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
